// File: rtl/mac_engine_vec_pkg.sv
// Shared types and default widths for the multi-lane MAC engine.
package mac_engine_vec_pkg;

    localparam int unsigned MAC_N_LANES = 4;
    localparam int unsigned MAC_DATA_W  = 16;
    localparam int unsigned MAC_ACC_W   = 48;
    localparam int unsigned MAC_OUT_W   = 32;
    localparam int unsigned MAC_CNT_W   = 16;
    localparam int unsigned MAC_SHIFT_W = $clog2(MAC_ACC_W);

    typedef enum logic {
        MODE_ACC = 1'b0,
        MODE_MUL = 1'b1
    } mac_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } mac_state_e;

    typedef struct packed {
        logic                   start;
        logic [MAC_CNT_W-1:0]   len;
        logic [MAC_SHIFT_W-1:0] shift;
        mac_mode_e              mode;
    } ctrl_engine_vec_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [MAC_CNT_W-1:0] cnt;
    } flags_engine_vec_t;

endpackage

// File: rtl/mac_engine_vec_lane.sv
// One MAC lane: S1 signed multiply, S2 accumulate or pass-through, then
// arithmetic shift right and saturation into the registered result word.
module mac_engine_vec_lane
    import mac_engine_vec_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned ACC_W  = MAC_ACC_W,
    parameter int unsigned OUT_W  = MAC_OUT_W
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       en_i,
    input  logic                       load_i,
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    input  logic                       s1_valid_i,
    input  logic                       first_i,
    input  logic                       last_i,
    input  mac_mode_e                  mode_i,
    input  logic [$clog2(ACC_W)-1:0]   shift_i,
    output logic [OUT_W-1:0]           c_data_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]         c_q, c_d;
    logic signed [ACC_W-1:0]  prod_ext, acc_base, sum, res, shifted;
    logic [OUT_W-1:0]         sat_c;

    always_comb begin
        prod_d   = prod_q;
        acc_d    = acc_q;
        c_d      = c_q;
        prod_ext = ACC_W'(prod_q);
        acc_base = first_i ? '0 : acc_q;
        sum      = acc_base + prod_ext;
        res      = (mode_i == MODE_MUL) ? prod_ext : sum;
        shifted  = res >>> shift_i;

        if (shifted > SAT_MAX) begin
            sat_c = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_c = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_c = shifted[OUT_W-1:0];
        end

        // Every stage holds while the result register is stalled.
        if (en_i) begin
            if (load_i) begin
                prod_d = PROD_W'(a_i) * PROD_W'(b_i);
            end
            if (s1_valid_i && (mode_i == MODE_ACC)) begin
                acc_d = sum;
            end
            if (s1_valid_i && ((mode_i == MODE_MUL) || last_i)) begin
                c_d = sat_c;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            prod_q <= '0;
            acc_q  <= '0;
            c_q    <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            c_q    <= c_d;
        end
    end

    assign c_data_o = c_q;

endmodule

// File: rtl/mac_engine_vec.sv
// Multi-lane MAC engine: joins the a/b operand streams, runs the job FSM and
// beat counter, and drives the shared two-stage lane pipeline.
module mac_engine_vec
    import mac_engine_vec_pkg::*;
#(
    parameter int unsigned N_LANES = MAC_N_LANES,
    parameter int unsigned DATA_W  = MAC_DATA_W,
    parameter int unsigned ACC_W   = MAC_ACC_W,
    parameter int unsigned OUT_W   = MAC_OUT_W,
    parameter int unsigned CNT_W   = MAC_CNT_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [CNT_W-1:0]             len_i,
    input  logic [$clog2(ACC_W)-1:0]     shift_i,
    input  logic                         mode_i,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    input  logic [N_LANES*DATA_W-1:0]    a_data_i,
    input  logic                         b_valid_i,
    output logic                         b_ready_o,
    input  logic [N_LANES*DATA_W-1:0]    b_data_i,
    output logic                         c_valid_o,
    input  logic                         c_ready_i,
    output logic [N_LANES*OUT_W-1:0]     c_data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             cnt_o
);

    localparam int unsigned SHIFT_W = $clog2(ACC_W);

    mac_state_e           state_q, state_d;
    ctrl_engine_vec_t     ctrl_c;
    flags_engine_vec_t    flags_q, flags_d;
    logic [MAC_CNT_W-1:0] len_q, len_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    mac_mode_e            mode_q, mode_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_first_q, s1_first_d;
    logic                 s1_last_q, s1_last_d;
    logic                 c_valid_q, c_valid_d;
    logic                 c_last_q, c_last_d;
    logic                 srst, en, can_take, fire, c_hs;
    logic [MAC_CNT_W-1:0] cnt_inc;

    assign srst     = rst_i | clear_i;
    assign en       = !c_valid_q || c_ready_i;
    assign can_take = (state_q == ST_RUN) && en && (flags_q.cnt < len_q);
    assign fire     = can_take && a_valid_i && b_valid_i;
    assign c_hs     = c_valid_q && c_ready_i;
    assign cnt_inc  = flags_q.cnt + MAC_CNT_W'(1);

    assign ctrl_c = '{start: start_i,
                      len:   MAC_CNT_W'(len_i),
                      shift: MAC_SHIFT_W'(shift_i),
                      mode:  mac_mode_e'(mode_i)};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        flags_d      = flags_q;
        flags_d.done = 1'b0;
        s1_valid_d   = s1_valid_q;
        s1_first_d   = s1_first_q;
        s1_last_d    = s1_last_q;
        c_valid_d    = c_valid_q;
        c_last_d     = c_last_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_c.start) begin
                    flags_d.cnt = '0;
                    if (ctrl_c.len != '0) begin
                        len_d   = ctrl_c.len;
                        shift_d = SHIFT_W'(ctrl_c.shift);
                        mode_d  = ctrl_c.mode;
                        state_d = ST_RUN;
                    end else begin
                        flags_d.done = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (fire) begin
                    flags_d.cnt = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // In MUL mode earlier results may drain here too; only the tagged last one ends the job.
                if (c_hs && c_last_q) begin
                    state_d      = ST_IDLE;
                    flags_d.done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        flags_d.busy = (state_d != ST_IDLE);

        if (en) begin
            s1_valid_d = fire;
            s1_first_d = fire && (flags_q.cnt == '0);
            s1_last_d  = fire && (cnt_inc == len_q);
            c_valid_d  = s1_valid_q && ((mode_q == MODE_MUL) || s1_last_q);
            c_last_d   = s1_last_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            shift_q    <= '0;
            mode_q     <= MODE_ACC;
            flags_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            c_valid_q  <= 1'b0;
            c_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            flags_q    <= flags_d;
            s1_valid_q <= s1_valid_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
            c_valid_q  <= c_valid_d;
            c_last_q   <= c_last_d;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        mac_engine_vec_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W)
        ) u_lane (
            .clk_i      (clk_i),
            .srst_i     (srst),
            .en_i       (en),
            .load_i     (fire),
            .a_i        (a_data_i[k*DATA_W +: DATA_W]),
            .b_i        (b_data_i[k*DATA_W +: DATA_W]),
            .s1_valid_i (s1_valid_q),
            .first_i    (s1_first_q),
            .last_i     (s1_last_q),
            .mode_i     (mode_q),
            .shift_i    (shift_q),
            .c_data_o   (c_data_o[k*OUT_W +: OUT_W])
        );
    end

    assign a_ready_o = can_take && b_valid_i;
    assign b_ready_o = can_take && a_valid_i;
    assign c_valid_o = c_valid_q;
    assign busy_o    = flags_q.busy;
    assign done_o    = flags_q.done;
    assign cnt_o     = CNT_W'(flags_q.cnt);

endmodule

// File: tb/tb_mac_engine_vec.sv
// Bench for mac_engine_vec: vector table, hand sequences and random jobs
// checked against a plain-arithmetic reference model.
module tb_mac_engine_vec;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 48;
    localparam int unsigned OW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = $clog2(AW);
    localparam longint MAXV = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (OW - 1));

    logic              clk_i = 1'b0;
    logic              rst_i, clear_i, start_i, mode_i;
    logic [CW-1:0]     len_i;
    logic [SW-1:0]     shift_i;
    logic              a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic [N*DW-1:0]   a_data_i, b_data_i;
    logic              c_valid_o, c_ready_i;
    logic [N*OW-1:0]   c_data_o;
    logic              busy_o, done_o;
    logic [CW-1:0]     cnt_o;

    mac_engine_vec #(
        .N_LANES (N), .DATA_W (DW), .ACC_W (AW), .OUT_W (OW), .CNT_W (CW)
    ) dut (
        .clk_i     (clk_i),     .rst_i     (rst_i),     .clear_i   (clear_i),
        .start_i   (start_i),   .len_i     (len_i),     .shift_i   (shift_i),
        .mode_i    (mode_i),    .a_valid_i (a_valid_i), .a_ready_o (a_ready_o),
        .a_data_i  (a_data_i),  .b_valid_i (b_valid_i), .b_ready_o (b_ready_o),
        .b_data_i  (b_data_i),  .c_valid_o (c_valid_o), .c_ready_i (c_ready_i),
        .c_data_o  (c_data_o),  .busy_o    (busy_o),    .done_o    (done_o),
        .cnt_o     (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cmp_cnt = 0;
    int fail_cnt = 0;
    logic [N*DW-1:0] beat_a[$], beat_b[$];
    logic [N*OW-1:0] got_q[$], exp_q[$];

    typedef struct {
        bit mode;
        int len;
        int sh;
        int a;
        int b;
        int exp;
    } vec_t;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] rep_d(input int v);
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [N*OW-1:0] rep_o(input int v);
        logic [N*OW-1:0] r;
        for (int k = 0; k < N; k++) r[k*OW +: OW] = OW'(v);
        return r;
    endfunction

    function automatic longint sat_shr(input longint v, input int sh);
        longint r;
        r = v >>> sh;
        if (r > MAXV) return MAXV;
        if (r < MINV) return MINV;
        return r;
    endfunction

    // Reference model: per-lane products, summed (ACC) or passed (MUL), shifted and clamped.
    task automatic build_expected(input bit mode, input int len, input int sh);
        longint acc [N];
        longint p;
        logic [N*DW-1:0] va, vb;
        logic [N*OW-1:0] r;
        exp_q.delete();
        for (int k = 0; k < N; k++) acc[k] = 0;
        for (int i = 0; i < len; i++) begin
            va = beat_a[i];
            vb = beat_b[i];
            for (int k = 0; k < N; k++) begin
                p = longint'($signed(va[k*DW +: DW])) * longint'($signed(vb[k*DW +: DW]));
                acc[k] += p;
                r[k*OW +: OW] = OW'(sat_shr(p, sh));
            end
            if (mode) exp_q.push_back(r);
        end
        if (!mode) begin
            for (int k = 0; k < N; k++) r[k*OW +: OW] = OW'(sat_shr(acc[k], sh));
            exp_q.push_back(r);
        end
    endtask

    task automatic compare_results(input string tag);
        logic [N*OW-1:0] g, e;
        check({tag, " result count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            g = got_q[i];
            e = exp_q[i];
            for (int k = 0; k < N; k++)
                check($sformatf("%s r%0d lane%0d", tag, i, k), $signed(g[k*OW +: OW]), $signed(e[k*OW +: OW]));
        end
    endtask

    // Drives one job from beat_a/beat_b and collects every handshaken c beat.
    // rdy: 0 = always ready, 1 = 1010 pattern, 2 = random.
    task automatic run_job(input bit mode, input int len, input int sh, input int gap,
                           input int rdy, input bit poke, input string tag);
        int idx, iter, dn, lat_err, stall_err, aonly_err, extra, e;
        int fires[$];
        bit done_seen, held;
        logic [N*OW-1:0] held_data;
        idx = 0; iter = 0; dn = 0; lat_err = 0; stall_err = 0; aonly_err = 0; extra = 0;
        done_seen = 0; held = 0; held_data = '0;
        got_q.delete();
        mode_i = mode; shift_i = SW'(sh); len_i = CW'(len);
        while (!done_seen && iter < 40 * len + 60) begin
            start_i = (iter == 0) || (poke && iter == 4);
            if (poke && iter == 4) begin
                len_i  = CW'(1);
                mode_i = ~mode;
            end
            if (idx < len) begin
                a_data_i = beat_a[idx];
                b_data_i = beat_b[idx];
            end
            a_valid_i = (idx < len) && ($urandom_range(99) >= gap);
            b_valid_i = (idx < len) && ($urandom_range(99) >= gap);
            case (rdy)
                0:       c_ready_i = 1'b1;
                1:       c_ready_i = (iter % 2 == 0);
                default: c_ready_i = 1'($urandom_range(1));
            endcase
            @(negedge clk_i);
            if ((a_ready_o && a_valid_i) != (b_ready_o && b_valid_i)) aonly_err++;
            if (held && (!c_valid_o || c_data_o !== held_data)) stall_err++;
            held = c_valid_o && !c_ready_i;
            held_data = c_data_o;
            if (c_valid_o && c_ready_i) begin
                got_q.push_back(c_data_o);
                if (rdy == 0) begin
                    if (fires.size() == 0) lat_err++;
                    else begin
                        e = mode ? fires.pop_front() : fires[fires.size()-1];
                        if (iter != e + 2) lat_err++;
                    end
                end
            end
            if (a_valid_i && a_ready_o && b_valid_i && b_ready_o) begin
                fires.push_back(iter);
                idx++;
            end
            if (done_o) begin
                dn++;
                done_seen = 1;
            end
            @(posedge clk_i); #1;
            iter++;
        end
        start_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; c_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            if (done_o) dn++;
            if (c_valid_o) extra++;
            @(posedge clk_i); #1;
        end
        check({tag, " finished in budget"}, done_seen, 1);
        check({tag, " beats accepted"}, idx, len);
        check({tag, " done pulses"}, dn, 1);
        check({tag, " cnt_o"}, cnt_o, len);
        check({tag, " one-sided accepts"}, aonly_err, 0);
        check({tag, " stall hold errors"}, stall_err, 0);
        check({tag, " extra c beats"}, extra, 0);
        if (rdy == 0) check({tag, " latency errors"}, lat_err, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl [8];
        logic [N*DW-1:0] v;
        logic [N*OW-1:0] r;
        int n, m, l, s, g, rd;
        bit seen;

        tbl[0] = '{mode: 0, len: 4, sh: 0, a: 3,      b: 5,      exp: 60};
        tbl[1] = '{mode: 0, len: 2, sh: 4, a: 32767,  b: 32767,  exp: 32767};
        tbl[2] = '{mode: 0, len: 1, sh: 4, a: -32768, b: -32768, exp: 32767};
        tbl[3] = '{mode: 1, len: 3, sh: 0, a: -7,     b: 9,      exp: -63};
        tbl[4] = '{mode: 0, len: 5, sh: 1, a: -100,   b: 3,      exp: -750};
        tbl[5] = '{mode: 0, len: 1, sh: 0, a: 32767,  b: -32768, exp: -32768};
        tbl[6] = '{mode: 0, len: 3, sh: 2, a: -1,     b: 1,      exp: -1};
        tbl[7] = '{mode: 1, len: 2, sh: 3, a: 100,    b: 100,    exp: 1250};

        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0; shift_i = '0; mode_i = 1'b0;
        a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0; c_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset c_valid_o", c_valid_o, 0);
        check("reset c_data_o", c_data_o, 0);
        check("reset busy_o", busy_o, 0);
        check("reset done_o", done_o, 0);
        check("reset cnt_o", cnt_o, 0);
        check("reset a_ready_o", a_ready_o, 0);
        @(posedge clk_i); #1;

        for (int t = 0; t < 8; t++) begin
            beat_a.delete(); beat_b.delete(); exp_q.delete();
            for (int i = 0; i < tbl[t].len; i++) begin
                beat_a.push_back(rep_d(tbl[t].a));
                beat_b.push_back(rep_d(tbl[t].b));
                if (tbl[t].mode) exp_q.push_back(rep_o(tbl[t].exp));
            end
            if (!tbl[t].mode) exp_q.push_back(rep_o(tbl[t].exp));
            run_job(tbl[t].mode, tbl[t].len, tbl[t].sh, 0, 0, 0, $sformatf("vec%0d", t));
            compare_results($sformatf("vec%0d", t));
        end

        // MUL on lane 1 only; other lanes see zero operands.
        beat_a.delete(); beat_b.delete(); exp_q.delete();
        v = '0; v[DW +: DW] = DW'(2);  beat_a.push_back(v);
        v = '0; v[DW +: DW] = DW'(-3); beat_a.push_back(v);
        v = '0; v[DW +: DW] = DW'(7);  beat_a.push_back(v);
        v = '0; v[DW +: DW] = DW'(4);  beat_b.push_back(v); beat_b.push_back(v);
        v = '0; v[DW +: DW] = DW'(-1); beat_b.push_back(v);
        r = '0; r[OW +: OW] = OW'(8);   exp_q.push_back(r);
        r = '0; r[OW +: OW] = OW'(-12); exp_q.push_back(r);
        r = '0; r[OW +: OW] = OW'(-7);  exp_q.push_back(r);
        run_job(1'b1, 3, 0, 0, 0, 0, "lane1 mul");
        compare_results("lane1 mul");

        // MUL len 8 under 1010 back-pressure with gapped operand valids.
        beat_a.delete(); beat_b.delete();
        for (int i = 0; i < 8; i++) begin
            beat_a.push_back(N*DW'({$urandom, $urandom}));
            beat_b.push_back(N*DW'({$urandom, $urandom}));
        end
        build_expected(1'b1, 8, 2);
        run_job(1'b1, 8, 2, 40, 1, 0, "stall mul");
        compare_results("stall mul");

        // Zero-length job: no beats, done one cycle after start.
        a_valid_i = 1'b1; b_valid_i = 1'b1; c_ready_i = 1'b1;
        start_i = 1'b1; len_i = '0; mode_i = 1'b0; shift_i = '0;
        @(negedge clk_i);
        check("len0 done before start edge", done_o, 0);
        @(posedge clk_i); #1 start_i = 1'b0;
        @(negedge clk_i);
        check("len0 done pulse", done_o, 1);
        check("len0 a_ready_o", a_ready_o, 0);
        check("len0 b_ready_o", b_ready_o, 0);
        check("len0 busy_o", busy_o, 0);
        check("len0 cnt_o", cnt_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("len0 done cleared", done_o, 0);
        check("len0 no c beat", c_valid_o, 0);
        @(posedge clk_i); #1 a_valid_i = 1'b0; b_valid_i = 1'b0;

        // Start pulse mid-job is ignored.
        beat_a.delete(); beat_b.delete();
        for (int i = 0; i < 8; i++) begin
            beat_a.push_back(N*DW'({$urandom, $urandom}));
            beat_b.push_back(N*DW'({$urandom, $urandom}));
        end
        build_expected(1'b0, 8, 20);
        run_job(1'b0, 8, 20, 30, 0, 1, "start during run");
        compare_results("start during run");

        // Clear while a result is stalled in DRAIN.
        a_data_i = rep_d(2); b_data_i = rep_d(3);
        a_valid_i = 1'b1; b_valid_i = 1'b1; c_ready_i = 1'b0;
        start_i = 1'b1; len_i = CW'(2); mode_i = 1'b0; shift_i = '0;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            @(negedge clk_i);
            seen = c_valid_o;
            @(posedge clk_i); #1 start_i = 1'b0;
            n++;
        end
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        @(negedge clk_i);
        check("clear: result reached", seen, 1);
        check("clear: stalled c_valid_o", c_valid_o, 1);
        check("clear: stalled lane0", $signed(c_data_o[OW-1:0]), 12);
        check("clear: busy in drain", busy_o, 1);
        @(posedge clk_i); #1 clear_i = 1'b1;
        @(posedge clk_i); #1 clear_i = 1'b0;
        @(negedge clk_i);
        check("clear: c_valid_o dropped", c_valid_o, 0);
        check("clear: busy_o", busy_o, 0);
        check("clear: done_o", done_o, 0);
        check("clear: cnt_o", cnt_o, 0);
        c_ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("clear: done_o stays low", done_o, 0);
        @(posedge clk_i); #1;
        beat_a.delete(); beat_b.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            beat_a.push_back(rep_d(3));
            beat_b.push_back(rep_d(5));
        end
        exp_q.push_back(rep_o(60));
        run_job(1'b0, 4, 0, 0, 0, 0, "after clear");
        compare_results("after clear");

        // Random jobs against the reference model.
        for (int j = 0; j < 10; j++) begin
            m  = $urandom_range(1);
            l  = $urandom_range(1, 12);
            s  = (j % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 34);
            g  = $urandom_range(0, 50);
            rd = $urandom_range(0, 2);
            beat_a.delete(); beat_b.delete();
            for (int i = 0; i < l; i++) begin
                if (j % 2 == 1) begin
                    for (int k = 0; k < N; k++) begin
                        v[k*DW +: DW] = DW'(int'($urandom_range(100)) - 50);
                    end
                    beat_a.push_back(v);
                    for (int k = 0; k < N; k++) begin
                        v[k*DW +: DW] = DW'(int'($urandom_range(100)) - 50);
                    end
                    beat_b.push_back(v);
                end else begin
                    beat_a.push_back(N*DW'({$urandom, $urandom}));
                    beat_b.push_back(N*DW'({$urandom, $urandom}));
                end
            end
            build_expected(1'(m), l, s);
            run_job(1'(m), l, s, g, rd, 0, $sformatf("rand%0d", j));
            compare_results($sformatf("rand%0d", j));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
